// File: rtl/onehot_code_decoder.sv
// onehot_code_decoder: qualifies a returned 16-bit select word for stability,
// decodes it back to its 4-bit code and hands each newly settled code to a
// valid/ready consumer. Illegal settled words are flagged and counted.
module onehot_code_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          in_word,
  input  logic                 in_valid,
  output logic [3:0]           code_out,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 overrun,
  input  logic                 clear_err
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW:0] SC_L = (RW+1)'(STABLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_LOCKED} state_t;

  state_t                r_state;
  logic [15:0]           r_cand;
  logic [RW-1:0]         r_run;
  logic [15:0]           r_committed;
  logic                  r_have;
  logic [3:0]            r_code;
  logic                  r_code_vld;
  logic                  r_err_pulse;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic                  r_overrun;

  logic [RW:0]           w_run_nx;
  logic                  w_same;
  logic                  w_qual;
  logic                  w_new;
  logic                  w_legal;
  logic [3:0]            w_dec;
  logic                  w_load;
  logic                  w_err;

  // Decode the incoming word: all-zero, all-ones, or a single bit in 1..14.
  always_comb begin
    w_legal = 1'b0;
    w_dec   = 4'd0;
    if (in_word == 16'h0000) begin
      w_legal = 1'b1;
    end else if (in_word == 16'hFFFF) begin
      w_legal = 1'b1;
      w_dec   = 4'd15;
    end else begin
      for (int k = 1; k <= 14; k++) begin
        if (in_word == (16'h0001 << k)) begin
          w_legal = 1'b1;
          w_dec   = 4'(k);
        end
      end
    end
  end

  // Qualify detection: the sample taken this edge completes a stable run.
  // In every qualifying case the qualified word is the current in_word.
  always_comb begin
    w_run_nx = {1'b0, r_run} + 1'b1;
    w_same   = (in_word == r_cand);
    w_qual   = 1'b0;
    if (in_valid) begin
      case (r_state)
        S_IDLE:   w_qual = (STABLE_CYCLES == 1);
        S_QUAL:   w_qual = w_same ? (w_run_nx == SC_L) : (STABLE_CYCLES == 1);
        S_LOCKED: w_qual = !w_same && (STABLE_CYCLES == 1);
        default:  w_qual = 1'b0;
      endcase
    end
    // A re-settle on the already committed word is neither delivered nor counted.
    w_new  = w_qual && !(r_have && (in_word == r_committed));
    w_load = w_new && w_legal;
    w_err  = w_new && !w_legal;
  end

  // Run qualification FSM, committed-word tracking, handshake and error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cand      <= '0;
      r_run       <= '0;
      r_committed <= '0;
      r_have      <= 1'b0;
      r_code      <= '0;
      r_code_vld  <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (in_valid) begin
        case (r_state)
          S_IDLE: begin
            r_cand  <= in_word;
            r_run   <= RW'(1);
            r_state <= w_qual ? S_LOCKED : S_QUAL;
          end
          S_QUAL: begin
            if (!w_same) begin
              r_cand  <= in_word;
              r_run   <= RW'(1);
              r_state <= w_qual ? S_LOCKED : S_QUAL;
            end else if (w_qual) begin
              r_state <= S_LOCKED;
            end else begin
              r_run <= w_run_nx[RW-1:0];
            end
          end
          S_LOCKED: begin
            if (!w_same) begin
              r_cand  <= in_word;
              r_run   <= RW'(1);
              r_state <= w_qual ? S_LOCKED : S_QUAL;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end

      if (w_new) begin
        r_committed <= in_word;
        r_have      <= 1'b1;
      end

      // A fresh legal code replaces whatever is held; otherwise a handshake empties it.
      if (w_load) begin
        r_code     <= w_dec;
        r_code_vld <= 1'b1;
      end else if (r_code_vld && code_ready) begin
        r_code_vld <= 1'b0;
      end

      r_err_pulse <= w_err;

      // Clear takes priority over a same-edge count or overrun event.
      if (clear_err) begin
        r_err_cnt <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}}))
          r_err_cnt <= r_err_cnt + 1'b1;
        if (w_load && r_code_vld && !code_ready)
          r_overrun <= 1'b1;
      end
    end
  end

  assign code_out   = r_code;
  assign code_valid = r_code_vld;
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_cnt;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_onehot_code_decoder.sv
// Directed bench for onehot_code_decoder with STABLE_CYCLES=4, ERR_CNT_W=8.
module tb_onehot_code_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_word;
  logic        in_valid;
  logic [3:0]  code_out;
  logic        code_valid;
  logic        code_ready;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic        overrun;
  logic        clear_err;

  int          total = 0;
  int          bad   = 0;
  int          nerr  = 0;
  logic [3:0]  acc[$];

  always #5 clk = ~clk;

  onehot_code_decoder #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
    .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
    .err_pulse(err_pulse), .err_count(err_count), .overrun(overrun),
    .clear_err(clear_err)
  );

  // Record every accepted code and every error pulse as seen by the consumer.
  always @(posedge clk) begin
    if (!rst && code_valid && code_ready) acc.push_back(code_out);
    if (!rst && err_pulse) nerr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a word for n clock edges; returns at a falling edge.
  task automatic put(input logic [15:0] w, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      in_word  = w;
      in_valid = v;
      @(negedge clk);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".code_out"}, 32'(code_out), 0);
    chk({tag, ".code_valid"}, 32'(code_valid), 0);
    chk({tag, ".err_pulse"}, 32'(err_pulse), 0);
    chk({tag, ".err_count"}, 32'(err_count), 0);
    chk({tag, ".overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    rst = 1'b1; in_word = '0; in_valid = 1'b0; code_ready = 1'b0; clear_err = 1'b0;
    put(16'h0, 1'b0, 3);
    chk_idle("reset");
    rst = 1'b0;

    // Code 6 appears after four samples and is held until accepted.
    put(16'h0040, 1'b1, 3);
    chk("c6_early", 32'(code_valid), 0);
    put(16'h0040, 1'b1, 1);
    chk("c6_valid", 32'(code_valid), 1);
    chk("c6_code", 32'(code_out), 6);
    put(16'h0040, 1'b1, 3);
    chk("c6_hold_v", 32'(code_valid), 1);
    chk("c6_hold_c", 32'(code_out), 6);
    code_ready = 1'b1;
    put(16'h0, 1'b0, 1);
    chk("c6_taken", 32'(code_valid), 0);
    chk("c6_nacc", 32'(acc.size()), 1);

    // 0xFFFF then 0x0000 with the consumer always ready.
    put(16'hFFFF, 1'b1, 6);
    put(16'h0000, 1'b1, 6);
    chk("ff00_nacc", 32'(acc.size()), 3);
    chk("ff_code", 32'(acc[1]), 15);
    chk("00_code", 32'(acc[2]), 0);
    chk("ff00_v", 32'(code_valid), 0);

    // Illegal word: one pulse, one count, no code, no repeat while held.
    put(16'h0003, 1'b1, 4);
    chk("ill_pulse", 32'(err_pulse), 1);
    chk("ill_cnt", 32'(err_count), 1);
    chk("ill_nov", 32'(code_valid), 0);
    put(16'h0003, 1'b1, 1);
    chk("ill_pulse_end", 32'(err_pulse), 0);
    put(16'h0003, 1'b1, 9);
    chk("ill_npulse", 32'(nerr), 1);
    chk("ill_cnt_hold", 32'(err_count), 1);

    // A different word breaks the run.
    put(16'h0010, 1'b1, 3);
    put(16'h0020, 1'b1, 1);
    put(16'h0010, 1'b1, 3);
    chk("brk_nov", 32'(code_valid), 0);
    chk("brk_nacc", 32'(acc.size()), 3);
    put(16'h0010, 1'b1, 1);
    chk("brk_v", 32'(code_valid), 1);
    chk("brk_code", 32'(code_out), 4);

    // Idle gaps inside a run neither advance nor break it.
    put(16'h0008, 1'b1, 2);
    put(16'h0000, 1'b0, 3);
    put(16'h0008, 1'b1, 1);
    chk("gap_nov", 32'(code_valid), 0);
    put(16'h0008, 1'b1, 1);
    chk("gap_v", 32'(code_valid), 1);
    chk("gap_code", 32'(code_out), 3);
    put(16'h0, 1'b0, 2);

    // Overrun: second legal code overwrites an undelivered one.
    code_ready = 1'b0;
    put(16'h0004, 1'b1, 4);
    chk("ov_code1", 32'(code_out), 2);
    chk("ov_pre", 32'(overrun), 0);
    put(16'h0010, 1'b1, 4);
    chk("ov_code2", 32'(code_out), 4);
    chk("ov_v", 32'(code_valid), 1);
    chk("ov_set", 32'(overrun), 1);
    clear_err = 1'b1;
    put(16'h0010, 1'b1, 1);
    clear_err = 1'b0;
    chk("clr_ov", 32'(overrun), 0);
    chk("clr_cnt", 32'(err_count), 0);
    chk("clr_v", 32'(code_valid), 1);

    // Clear on the same edge as an illegal qualify: count lost, pulse kept.
    put(16'h0005, 1'b1, 3);
    clear_err = 1'b1;
    put(16'h0005, 1'b1, 1);
    clear_err = 1'b0;
    chk("clrw_pulse", 32'(err_pulse), 1);
    chk("clrw_cnt", 32'(err_count), 0);

    // Consume and load on the same edge: no overrun.
    put(16'h0040, 1'b1, 3);
    code_ready = 1'b1;
    put(16'h0040, 1'b1, 1);
    chk("swap_v", 32'(code_valid), 1);
    chk("swap_code", 32'(code_out), 6);
    chk("swap_ov", 32'(overrun), 0);
    chk("swap_old", 32'(acc[acc.size()-1]), 4);
    put(16'h0, 1'b0, 1);
    chk("swap_new", 32'(acc[acc.size()-1]), 6);
    chk("swap_done", 32'(code_valid), 0);

    // Saturation: 256 alternating illegal words.
    for (int i = 0; i < 256; i++) put(i[0] ? 16'h0005 : 16'h0003, 1'b1, 4);
    chk("sat_cnt", 32'(err_count), 255);
    chk("sat_pulse", 32'(err_pulse), 1);

    // Reset mid-handshake forgets the committed word.
    code_ready = 1'b0;
    put(16'h0100, 1'b1, 4);
    chk("rst_pre_v", 32'(code_valid), 1);
    chk("rst_pre_c", 32'(code_out), 8);
    rst = 1'b1;
    put(16'h0100, 1'b1, 2);
    chk_idle("rst_mid");
    rst = 1'b0;
    put(16'h0100, 1'b1, 3);
    chk("rst_re_nov", 32'(code_valid), 0);
    put(16'h0100, 1'b1, 1);
    chk("rst_re_v", 32'(code_valid), 1);
    chk("rst_re_c", 32'(code_out), 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
